data_mem_responder: RTL and testbench

Memory-side responder for the execute unit's data-memory handshake: accepts byte/half/word stores and word loads, including back-to-back 8-word vector bursts. Wraps a synchronous, byte-enabled single-port RAM behind a small FSM. Sits between the execute stage's memory master port and on-chip data RAM. Returns load data right-aligned to the addressed byte lane, so the initiator's sign/zero extension works on bits [7:0] and [15:0].

---
 rtl/mem_pkg.sv | 42 ++++
 rtl/data_ram.sv | 33 +++
 rtl/data_mem_responder.sv | 130 +++++++++++++
 tb/tb_data_mem_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// store width codes and the store byte-enable / alignment-fault helper.
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_RESP = 2'd1,
      ST_WR_ACK  = 2'd2
   } mem_state_t;

   localparam logic [2:0] MEM_W_BYTE = 3'd1;
   localparam logic [2:0] MEM_W_HALF = 3'd2;
   localparam logic [2:0] MEM_W_WORD = 3'd4;

   typedef struct packed {
      logic       fault;
      logic [3:0] mask;
   } mem_be_t;

   // Lane mask for a store of the given width at byte offset within the word.
   // Misaligned halves/words and unknown width codes report a fault.
   function automatic mem_be_t mem_byte_en(input logic [2:0] width,
                                           input logic [1:0] offset);
      mem_be_t r;
      r.fault = 1'b0;
      r.mask  = 4'b0000;
      case (width)
         MEM_W_BYTE: r.mask = 4'b0001 << offset;
         MEM_W_HALF: begin
            r.mask  = 4'b0011 << offset;
            r.fault = offset[0];
         end
         MEM_W_WORD: begin
            r.mask  = 4'b1111;
            r.fault = (offset != 2'd0);
         end
         default:    r.fault = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port data RAM with per-byte-lane write enables and a registered
// read port (one-cycle latency). Contents are not reset.
// Ports:
//   i_clk  clock
//   en     access enable (read when we==0, write otherwise)
//   we     byte-lane write enables
//   addr   word index
//   wdata  write data, already lane-aligned
//   rdata  read data, valid the cycle after a read access
module data_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              i_clk,
   input  logic              en,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge i_clk) begin
      if (en) begin
         for (int l = 0; l < 4; l++) begin
            if (we[l]) mem[addr][8*l +: 8] <= wdata[8*l +: 8];
         end
         if (we == 4'b0000) rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the execute unit's data-memory handshake.
// Services byte/half/word stores and word loads against data_ram; load data
// is returned right-aligned to the addressed byte lane, zero-filled.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_addr                byte address, held by the initiator until done
//   i_data, i_wr_width    store data (right-aligned) and size in bytes
//   i_wr_valid/o_wr_ready store handshake
//   i_rd_ready/o_rd_valid load handshake, o_data load data
//   o_err                 pulses with the completing handshake of a faulted access
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for a request; stores win over loads
// ST_RD_RESP | RAM read data presented, o_rd_valid high
// ST_WR_ACK  | store acknowledged, RAM written if still requested and legal
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [31:0]           i_addr,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_wr_valid,
   output logic                  o_wr_ready,
   input  logic [2:0]            i_wr_width,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_rd_valid,
   input  logic                  i_rd_ready,
   output logic                  o_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   mem_state_t            state;
   logic [AW-1:0]         word_idx;
   logic [1:0]            offset;
   logic [3:0]            be_mask;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  fault;

   logic                  req_oob;
   mem_be_t               be_req;
   logic                  rd_issue;
   logic                  ram_en;
   logic [3:0]            ram_we;
   logic [AW-1:0]         ram_addr;
   logic [31:0]           ram_q;

   // Word indices beyond the RAM fault rather than alias.
   assign req_oob  = |i_addr[31:AW+2];
   assign be_req   = mem_byte_en(i_wr_width, i_addr[1:0]);
   assign rd_issue = (state == ST_IDLE) && !i_wr_valid && i_rd_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         o_wr_ready <= 1'b0;
         o_rd_valid <= 1'b0;
         fault      <= 1'b0;
         word_idx   <= '0;
         offset     <= '0;
         be_mask    <= '0;
         wdata      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_wr_valid) begin
                  word_idx   <= i_addr[AW+1:2];
                  offset     <= i_addr[1:0];
                  be_mask    <= be_req.mask;
                  wdata      <= i_data << {i_addr[1:0], 3'b000};
                  fault      <= be_req.fault | req_oob;
                  o_wr_ready <= 1'b1;
                  state      <= ST_WR_ACK;
               end else if (i_rd_ready) begin
                  word_idx   <= i_addr[AW+1:2];
                  offset     <= i_addr[1:0];
                  fault      <= req_oob;
                  o_rd_valid <= 1'b1;
                  state      <= ST_RD_RESP;
               end
            end
            // Completed or abandoned, the response lasts exactly one cycle.
            ST_RD_RESP: begin
               o_rd_valid <= 1'b0;
               state      <= ST_IDLE;
            end
            ST_WR_ACK: begin
               o_wr_ready <= 1'b0;
               state      <= ST_IDLE;
            end
            default: begin
               o_wr_ready <= 1'b0;
               o_rd_valid <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

   // Write commits in the WR_ACK cycle only if the initiator still holds
   // i_wr_valid; reset in that cycle blocks the write.
   assign ram_we   = (state == ST_WR_ACK && i_wr_valid && !fault && !i_rst)
                     ? be_mask : 4'b0000;
   assign ram_en   = (rd_issue && !req_oob) || (ram_we != 4'b0000);
   assign ram_addr = (state == ST_WR_ACK) ? word_idx : i_addr[AW+1:2];

   data_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .i_clk (i_clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wdata),
      .rdata (ram_q)
   );

   assign o_data = (state == ST_RD_RESP && !fault)
                   ? (ram_q >> {offset, 3'b000}) : '0;

   // Error only accompanies a handshake that actually completes.
   assign o_err  = fault && ((state == ST_RD_RESP && i_rd_ready) ||
                             (state == ST_WR_ACK  && i_wr_valid));

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        wr_valid;
   logic        wr_ready;
   logic [2:0]  width;
   logic [31:0] rdata;
   logic        rd_valid;
   logic        rd_ready;
   logic        err;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Byte-addressed reference memory.
   logic [7:0] ref_mem [4*DEPTH];

   data_mem_responder #(
      .DATA_WIDTH  (32),
      .DEPTH_WORDS (DEPTH)
   ) u_dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_addr     (addr),
      .i_data     (wdata),
      .i_wr_valid (wr_valid),
      .o_wr_ready (wr_ready),
      .i_wr_width (width),
      .o_data     (rdata),
      .o_rd_valid (rd_valid),
      .i_rd_ready (rd_ready),
      .o_err      (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic bit store_faults(input logic [31:0] a, input logic [2:0] w);
      if (a / 4 >= DEPTH) return 1'b1;
      case (w)
         3'd1:    return 1'b0;
         3'd2:    return (a % 2) != 0;
         3'd4:    return (a % 4) != 0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a);
      logic [31:0] r;
      int off, base;
      r = '0;
      if (a / 4 >= DEPTH) return r;
      off  = int'(a % 4);
      base = int'(a) - off;
      for (int i = off; i < 4; i++) r[8*(i-off) +: 8] = ref_mem[base+i];
      return r;
   endfunction

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w);
      bit flt;
      flt = store_faults(a, w);
      addr = a; wdata = d; width = w; wr_valid = 1'b1; rd_ready = 1'b0;
      @(negedge clk);
      check_eq("st_ready_early", 32'(wr_ready), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("st_ready", 32'(wr_ready), 1);
      check_eq("st_err", 32'(err), 32'(flt));
      check_eq("st_rvalid", 32'(rd_valid), 0);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      if (!flt) for (int i = 0; i < int'(w); i++) ref_mem[int'(a)+i] = d[8*i +: 8];
   endtask

   task automatic do_load(input logic [31:0] a);
      logic [31:0] exp_d;
      bit oob;
      exp_d = ref_load(a);
      oob   = (a / 4 >= DEPTH);
      addr = a; rd_ready = 1'b1; wr_valid = 1'b0;
      @(negedge clk);
      check_eq("ld_valid_early", 32'(rd_valid), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("ld_valid", 32'(rd_valid), 1);
      check_eq("ld_data", rdata, exp_d);
      check_eq("ld_err", 32'(err), 32'(oob));
      check_eq("ld_wready", 32'(wr_ready), 0);
      @(posedge clk); #1;
      rd_ready = 1'b0;
   endtask

   initial begin
      int c0;
      rst = 1'b1; addr = '0; wdata = '0; width = 3'd4; wr_valid = 1'b0; rd_ready = 1'b0;
      for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_wready", 32'(wr_ready), 0);
      check_eq("rst_rvalid", 32'(rd_valid), 0);
      check_eq("rst_data", rdata, 0);
      check_eq("rst_err", 32'(err), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Preload words 0..127 through the store port.
      for (int i = 0; i < 128; i++) do_store(32'(4*i), $urandom, 3'd4);

      // Directed scenarios.
      do_store(32'h40, 32'h8899AABB, 3'd4);
      do_load(32'h41);
      do_store(32'h42, 32'h0000005A, 3'd1);
      do_load(32'h40);
      do_store(32'h43, 32'hDEADBEEF, 3'd4);
      do_load(32'h40);
      do_store(32'h46, 32'h0000C3D4, 3'd2);
      do_store(32'h45, 32'h0000FFFF, 3'd2);
      do_store(32'h44, 32'h11111111, 3'd3);
      do_load(32'h44);

      for (int i = 0; i < 8; i++) do_store(32'(32'h100 + 4*i), 32'(i+1), 3'd4);
      c0 = cyc;
      for (int i = 0; i < 8; i++) do_load(32'(32'h100 + 4*i));
      check_eq("burst_cycles", 32'(cyc - c0), 16);

      do_load(32'(4*DEPTH));
      do_store(32'(4*DEPTH), 32'h12345678, 3'd4);

      // Reset asserted while in WR_ACK: the pending write must not land.
      do_store(32'h80, 32'hCAFEF00D, 3'd4);
      addr = 32'h80; wdata = 32'h12345678; width = 3'd4; wr_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("rstw_wready", 32'(wr_ready), 0);
      check_eq("rstw_rvalid", 32'(rd_valid), 0);
      check_eq("rstw_data", rdata, 0);
      check_eq("rstw_err", 32'(err), 0);
      rst = 1'b0; wr_valid = 1'b0;
      @(posedge clk); #1;
      do_load(32'h80);

      // Store and load requested together: store goes first.
      addr = 32'h84; wdata = 32'hA5A55A5A; width = 3'd4; wr_valid = 1'b1; rd_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("both_wready", 32'(wr_ready), 1);
      check_eq("both_rvalid", 32'(rd_valid), 0);
      @(posedge clk); #1;
      wr_valid = 1'b0; rd_ready = 1'b0;
      for (int i = 0; i < 4; i++) ref_mem[32'h84 + i] = wdata[8*i +: 8];
      do_load(32'h84);

      // Randomized traffic.
      for (int k = 0; k < 300; k++) begin
         logic [31:0] a;
         logic [2:0]  w;
         int          r;
         r = int'($urandom_range(0, 15));
         if (r == 0)      a = 32'(4*DEPTH) + 32'($urandom_range(0, 4095));
         else if (r == 1) a = $urandom | 32'h8000_0000;
         else             a = 32'($urandom_range(0, 511));
         if ($urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 7))
               0, 1:    w = 3'd1;
               2, 3:    w = 3'd2;
               4, 5:    w = 3'd4;
               default: w = 3'($urandom_range(0, 7));
            endcase
            do_store(a, $urandom, w);
         end else begin
            do_load(a);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
